nms_corner_select: RTL and testbench
====================================

// Module: nms_corner_select
// PURPOSE
//  Non-maximum-suppression decision stage directly downstream of the NMS 3x3 line-buffer window.
//  Compares the window centre score against its 8 neighbours and keeps local maxima only.
//  Pushes surviving corners (x, y, score) into an output FIFO with a valid/ready interface.
//  Maintains per-frame corner statistics for the host.
// PARAMETERS
//  FIFO_DEPTH  16  output FIFO entries; power of 2, >=2
//  CNT_W       16  width of per-frame corner counter
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-high
//  ce           in   1   global enable; pipeline advances only when 1
//  frame_start  in   1   1-cycle pulse: clears corner_cnt and overflow (independent of ce)
//  win_vld      in   1   3x3 window valid (window line-buffer valid output)
//  w00..w22     in   34  window words {x[33:24], y[23:14], iscorner[13], score[12:0]}; w11 = centre
//  out_valid    out  1   FIFO head holds a corner
//  out_ready    in   1   consumer accepts head when out_valid & out_ready
//  out_x        out  10  corner column
//  out_y        out  10  corner row
//  out_score    out  13  corner score
//  corner_cnt   out  CNT_W  corners detected this frame, saturating
//  overflow     out  1   sticky: a detected corner was dropped because FIFO was full
// BEHAVIOUR
//  Reset: all pipeline regs, FIFO pointers/count cleared; out_valid=0, out_x/out_y/out_score=0,
//   corner_cnt=0, overflow=0. Reset mid-frame discards in-flight and queued corners.
//  Stage 1 (ce=1): register centre x/y/score, win_vld & w11[13], and 8 compares on score[12:0]:
//   strict  s11 >  s   for w00,w01,w02,w10 (raster-earlier neighbours)
//   non-str s11 >= s   for w12,w20,w21,w22 (raster-later neighbours)
//   Asymmetric tie-break: of two equal adjacent maxima exactly one survives (the raster-earlier one).
//  Neighbours with iscorner=0 carry score 0; no special casing needed.
//  Stage 2 (ce=1): is_max = vld1 & iscorner1 & (score1!=0) & AND(all 8 compares).
//  Latency: window sampled at ce-cycle N -> push decision at ce-cycle N+2 (2 ce-qualified edges).
//  ce=0: stage 1/2 hold; no push generated; FIFO pop side still operates (out_ready honoured).
//  Push: is_max registered in stage 2 -> write {x,y,score} at wr_ptr on the next clk.
//   corner_cnt increments on every is_max, saturates at 2^CNT_W-1.
//   FIFO full and no pop same cycle -> entry dropped, overflow<=1, pointers unchanged.
//   FIFO full with pop same cycle -> push accepted (count unchanged).
//  Pop: out_valid & out_ready -> rd_ptr++. out_* show head combinationally from FIFO storage;
//   out_* are don't-care but stable when out_valid=0.
//  Empty with push same cycle: out_valid rises the following cycle (no bypass).
//  Pointers wrap modulo FIFO_DEPTH; count tracked in log2(FIFO_DEPTH)+1 bits.
//  frame_start: corner_cnt<=0, overflow<=0 (if is_max same cycle, counter becomes 1);
//   FIFO contents and pipeline untouched. rst has priority over frame_start.
// TESTING
//  1 Centre score 100, all neighbours 50, iscorner=1, win_vld=1 -> one entry (x,y,100) 2 ce-cycles later; corner_cnt=1.
//  2 Centre 80, w02=80 -> suppressed; centre 80, w21=80 -> kept (tie-break); centre iscorner=0 -> no push.
//  3 out_ready=0, 20 maxima streamed, DEPTH=16 -> 16 queued, overflow=1, corner_cnt=20; release ready -> 16 pops in order.
//  4 FIFO full, push and pop same cycle -> push accepted, occupancy stays 16, overflow unchanged.
//  5 ce toggled 1/0 every cycle during a maxima stream -> same outputs as ce=1 run, stretched; no duplicates.
//  6 rst asserted with 5 queued + 2 in pipeline -> out_valid=0 next cycle, nothing emitted afterwards;
//    frame_start -> corner_cnt=0, overflow=0.

Source files
------------

// File: rtl/nms_corner_select_if.sv
// Output stream of the NMS corner selector: one surviving corner per beat.
// Uses a valid/ready handshake; the design drives the master side.
interface nms_corner_select_if;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic [12:0] out_score;

    modport master (output out_valid, out_x, out_y, out_score, input out_ready);
    modport slave  (input out_valid, out_x, out_y, out_score, output out_ready);
endinterface

// File: rtl/nms_corner_select.sv
// Non-maximum-suppression decision stage: keeps 3x3-window local maxima and queues them
// as (x, y, score) in an output FIFO, with per-frame corner count and drop flag.
module nms_corner_select #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce_i,
    input  logic                 frame_start_i,
    input  logic                 win_vld_i,
    input  logic [33:0]          w00_i,
    input  logic [33:0]          w01_i,
    input  logic [33:0]          w02_i,
    input  logic [33:0]          w10_i,
    input  logic [33:0]          w11_i,
    input  logic [33:0]          w12_i,
    input  logic [33:0]          w20_i,
    input  logic [33:0]          w21_i,
    input  logic [33:0]          w22_i,
    nms_corner_select_if.master  out_if,
    output logic [CNT_W-1:0]     corner_cnt_o,
    output logic                 overflow_o
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

    // Stage 1 state
    logic [9:0]  x1_q, y1_q;
    logic [12:0] score1_q;
    logic        vld1_q, isc1_q;
    logic [7:0]  cmp1_q;
    logic [7:0]  cmp_d;

    // Stage 2 state
    logic [9:0]  x2_q, y2_q;
    logic [12:0] score2_q;
    logic        is_max_q;

    // FIFO state
    logic [32:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [CNT_W-1:0] corner_cnt_q;
    logic            overflow_q;

    logic        push_w, pop_w, full_w, wr_en_w, valid_w;
    logic [32:0] head_w;
    logic [12:0] s11_w;

    // Earlier neighbours need strict '>' and later ones '>=', so of two equal
    // adjacent maxima only the raster-earlier one survives.
    assign s11_w = w11_i[12:0];
    assign cmp_d = {s11_w >= w22_i[12:0], s11_w >= w21_i[12:0],
                    s11_w >= w20_i[12:0], s11_w >= w12_i[12:0],
                    s11_w >  w10_i[12:0], s11_w >  w02_i[12:0],
                    s11_w >  w01_i[12:0], s11_w >  w00_i[12:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q     <= '0;
            y1_q     <= '0;
            score1_q <= '0;
            vld1_q   <= 1'b0;
            isc1_q   <= 1'b0;
            cmp1_q   <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            score2_q <= '0;
            is_max_q <= 1'b0;
        end else if (ce_i) begin
            // NOTE: non-blocking assignments let stage 2 see the old stage-1 values on this edge.
            x1_q     <= w11_i[33:24];
            y1_q     <= w11_i[23:14];
            score1_q <= w11_i[12:0];
            vld1_q   <= win_vld_i;
            isc1_q   <= w11_i[13];
            cmp1_q   <= cmp_d;
            x2_q     <= x1_q;
            y2_q     <= y1_q;
            score2_q <= score1_q;
            is_max_q <= vld1_q & isc1_q & (score1_q != '0) & (&cmp1_q);
        end
    end

    // A decision held while ce=0 is pushed only once, on the next enabled edge.
    assign push_w  = ce_i & is_max_q;
    assign valid_w = (count_q != '0);
    assign pop_w   = valid_w & out_if.out_ready;
    assign full_w  = (count_q == DEPTH_C);
    assign wr_en_w = push_w & (~full_w | pop_w);

    // NOTE: storage has no reset; out_valid gates every read, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (wr_en_w) mem_q[wr_ptr_q] <= {x2_q, y2_q, score2_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en_w, pop_w})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Drop in the same cycle as frame_start still flags, so no loss goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            corner_cnt_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (frame_start_i)
                corner_cnt_q <= push_w ? CNT_W'(1) : '0;
            else if (push_w && corner_cnt_q != '1)
                corner_cnt_q <= corner_cnt_q + 1'b1;

            if (push_w && full_w && !pop_w)
                overflow_q <= 1'b1;
            else if (frame_start_i)
                overflow_q <= 1'b0;
        end
    end

    assign head_w           = mem_q[rd_ptr_q];
    assign out_if.out_valid = valid_w;
    assign out_if.out_x     = valid_w ? head_w[32:23] : '0;
    assign out_if.out_y     = valid_w ? head_w[22:13] : '0;
    assign out_if.out_score = valid_w ? head_w[12:0]  : '0;
    assign corner_cnt_o     = corner_cnt_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_nms_corner_select.sv
// Directed bench for nms_corner_select: suppression, tie-break, FIFO fill/overflow,
// simultaneous push/pop, ce stretching, reset and frame_start.
module tb_nms_corner_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, frame_start, win_vld;
    logic [33:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic [15:0] corner_cnt;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    nms_corner_select_if ifc ();

    nms_corner_select #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ce_i          (ce),
        .frame_start_i (frame_start),
        .win_vld_i     (win_vld),
        .w00_i (w00), .w01_i (w01), .w02_i (w02),
        .w10_i (w10), .w11_i (w11), .w12_i (w12),
        .w20_i (w20), .w21_i (w21), .w22_i (w22),
        .out_if        (ifc.master),
        .corner_cnt_o  (corner_cnt),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    wire [33:0] head = {ifc.out_valid, ifc.out_x, ifc.out_y, ifc.out_score};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic [9:0] x, input logic [9:0] y, input logic isc,
                           input logic [12:0] cs, input logic [12:0] ns);
        w11 = {x, y, isc, cs};
        w00 = {20'd0, 1'b1, ns}; w01 = {20'd0, 1'b1, ns}; w02 = {20'd0, 1'b1, ns};
        w10 = {20'd0, 1'b1, ns}; w12 = {20'd0, 1'b1, ns};
        w20 = {20'd0, 1'b1, ns}; w21 = {20'd0, 1'b1, ns}; w22 = {20'd0, 1'b1, ns};
    endtask

    // One-cycle window pulse, then wait until its push would have landed.
    task automatic fire();
        win_vld = 1'b1;
        tick();
        win_vld = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_one();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (head !== 34'd0) begin
            n_bad++; $display("FAIL reset_out: got %h want 0", head);
        end
        n_cmp++;
        if ({corner_cnt, overflow} !== 17'd0) begin
            n_bad++; $display("FAIL reset_stats: cnt=%0d ovf=%b want 0/0", corner_cnt, overflow);
        end
    endtask

    task automatic test_single_max();
        set_win(10'd5, 10'd7, 1'b1, 13'd100, 13'd50);
        win_vld = 1'b1;
        tick();
        win_vld = 1'b0;
        tick();
        n_cmp++;
        if (ifc.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_latency: out_valid=%b after 2 edges want 0", ifc.out_valid);
        end
        tick();
        n_cmp++;
        if (head !== {1'b1, 10'd5, 10'd7, 13'd100}) begin
            n_bad++; $display("FAIL single_entry: got %h want %h", head, {1'b1, 10'd5, 10'd7, 13'd100});
        end
        n_cmp++;
        if (corner_cnt !== 16'd1) begin
            n_bad++; $display("FAIL single_cnt: got %0d want 1", corner_cnt);
        end
        pop_one();
        n_cmp++;
        if (ifc.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_pop: out_valid=%b want 0", ifc.out_valid);
        end
    endtask

    task automatic test_tie_break();
        set_win(10'd1, 10'd2, 1'b1, 13'd80, 13'd50);
        w02[12:0] = 13'd80;
        fire();
        n_cmp++;
        if (ifc.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL tie_earlier: out_valid=%b want 0", ifc.out_valid);
        end
        set_win(10'd3, 10'd4, 1'b1, 13'd80, 13'd50);
        w21[12:0] = 13'd80;
        fire();
        n_cmp++;
        if (head !== {1'b1, 10'd3, 10'd4, 13'd80}) begin
            n_bad++; $display("FAIL tie_later: got %h want %h", head, {1'b1, 10'd3, 10'd4, 13'd80});
        end
        pop_one();
        set_win(10'd8, 10'd9, 1'b0, 13'd100, 13'd50);
        fire();
        n_cmp++;
        if (ifc.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL not_corner: out_valid=%b want 0", ifc.out_valid);
        end
        set_win(10'd8, 10'd9, 1'b1, 13'd0, 13'd0);
        fire();
        n_cmp++;
        if (ifc.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL zero_score: out_valid=%b want 0", ifc.out_valid);
        end
        n_cmp++;
        if (corner_cnt !== 16'd2) begin
            n_bad++; $display("FAIL tie_cnt: got %0d want 2", corner_cnt);
        end
    endtask

    task automatic test_overflow();
        pulse_frame_start();
        for (int i = 0; i < 20; i++) begin
            set_win(10'(i), 10'(i + 1), 1'b1, 13'(100 + i), 13'd50);
            win_vld = 1'b1;
            tick();
        end
        win_vld = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({overflow, corner_cnt} !== {1'b1, 16'd20}) begin
            n_bad++; $display("FAIL ovf_stats: ovf=%b cnt=%0d want 1/20", overflow, corner_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (head !== {1'b1, 10'(i), 10'(i + 1), 13'(100 + i)}) begin
                n_bad++; $display("FAIL ovf_pop%0d: got %h want %h", i, head, {1'b1, 10'(i), 10'(i + 1), 13'(100 + i)});
            end
            pop_one();
        end
        n_cmp++;
        if ({ifc.out_valid, overflow} !== 2'b01) begin
            n_bad++; $display("FAIL ovf_drained: valid=%b ovf=%b want 0/1", ifc.out_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        pulse_frame_start();
        n_cmp++;
        if ({overflow, corner_cnt} !== 17'd0) begin
            n_bad++; $display("FAIL fs_clear: ovf=%b cnt=%0d want 0/0", overflow, corner_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            set_win(10'(i), 10'(i + 1), 1'b1, 13'(200 + i), 13'd50);
            win_vld = 1'b1;
            tick();
        end
        win_vld = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({overflow, corner_cnt} !== {1'b0, 16'd16}) begin
            n_bad++; $display("FAIL full_stats: ovf=%b cnt=%0d want 0/16", overflow, corner_cnt);
        end
        set_win(10'd40, 10'd41, 1'b1, 13'd300, 13'd50);
        win_vld = 1'b1;
        tick();
        win_vld = 1'b0;
        tick();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        n_cmp++;
        if ({overflow, corner_cnt} !== {1'b0, 16'd17}) begin
            n_bad++; $display("FAIL pushpop_stats: ovf=%b cnt=%0d want 0/17", overflow, corner_cnt);
        end
        for (int i = 1; i < 16; i++) begin
            n_cmp++;
            if (head !== {1'b1, 10'(i), 10'(i + 1), 13'(200 + i)}) begin
                n_bad++; $display("FAIL pushpop_pop%0d: got %h want %h", i, head, {1'b1, 10'(i), 10'(i + 1), 13'(200 + i)});
            end
            pop_one();
        end
        n_cmp++;
        if (head !== {1'b1, 10'd40, 10'd41, 13'd300}) begin
            n_bad++; $display("FAIL pushpop_new: got %h want %h", head, {1'b1, 10'd40, 10'd41, 13'd300});
        end
        pop_one();
        n_cmp++;
        if (ifc.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL pushpop_empty: out_valid=%b want 0", ifc.out_valid);
        end
    endtask

    task automatic test_ce_toggle();
        ce = 1'b0;
        pulse_frame_start();
        n_cmp++;
        if (corner_cnt !== 16'd0) begin
            n_bad++; $display("FAIL ce_fs: cnt=%0d want 0", corner_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            set_win(10'(50 + k), 10'(60 + k), 1'b1, 13'(400 + k), 13'd50);
            win_vld = 1'b1;
            ce = 1'b1;
            tick();
            ce = 1'b0;
            tick();
        end
        win_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ce = ~ce;
            tick();
        end
        ce = 1'b1;
        n_cmp++;
        if (corner_cnt !== 16'd4) begin
            n_bad++; $display("FAIL ce_cnt: got %0d want 4", corner_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (head !== {1'b1, 10'(50 + k), 10'(60 + k), 13'(400 + k)}) begin
                n_bad++; $display("FAIL ce_pop%0d: got %h want %h", k, head, {1'b1, 10'(50 + k), 10'(60 + k), 13'(400 + k)});
            end
            pop_one();
        end
        n_cmp++;
        if (ifc.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL ce_dup: out_valid=%b want 0", ifc.out_valid);
        end
    endtask

    task automatic test_reset_midframe();
        pulse_frame_start();
        for (int i = 0; i < 7; i++) begin
            set_win(10'(70 + i), 10'(80 + i), 1'b1, 13'(500 + i), 13'd50);
            win_vld = 1'b1;
            tick();
        end
        win_vld = 1'b0;
        n_cmp++;
        if (corner_cnt !== 16'd5) begin
            n_bad++; $display("FAIL mid_cnt: got %0d want 5", corner_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({head, corner_cnt} !== 50'd0) begin
            n_bad++; $display("FAIL mid_rst: out=%h cnt=%0d want 0/0", head, corner_cnt);
        end
        repeat (5) tick();
        n_cmp++;
        if ({ifc.out_valid, corner_cnt} !== 17'd0) begin
            n_bad++; $display("FAIL mid_flush: valid=%b cnt=%0d want 0/0", ifc.out_valid, corner_cnt);
        end
        set_win(10'd90, 10'd91, 1'b1, 13'd600, 13'd50);
        fire();
        pulse_frame_start();
        n_cmp++;
        if ({corner_cnt, overflow} !== 17'd0) begin
            n_bad++; $display("FAIL fs_after_rst: cnt=%0d ovf=%b want 0/0", corner_cnt, overflow);
        end
        n_cmp++;
        if (head !== {1'b1, 10'd90, 10'd91, 13'd600}) begin
            n_bad++; $display("FAIL fs_keeps_fifo: got %h want %h", head, {1'b1, 10'd90, 10'd91, 13'd600});
        end
        pop_one();
    endtask

    initial begin
        rst = 1'b1;
        ce = 1'b1;
        frame_start = 1'b0;
        win_vld = 1'b0;
        ifc.out_ready = 1'b0;
        set_win(10'd0, 10'd0, 1'b0, 13'd0, 13'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_single_max();
        test_tie_break();
        test_overflow();
        test_full_push_pop();
        test_ce_toggle();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
